// File: rtl/preif_pc_gen_pkg.sv
// Shared CPU definitions used by the PREIF stage: exception bundle type and reset vector.
package preif_pc_gen_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

   // Exception flags that travel down the pipeline with each instruction.
   typedef struct packed {
      logic interrupt;
      logic adel_if;        // fetch address error (misaligned PC)
      logic reserved_instr;
      logic syscall;
      logic brk;
      logic eret;
      logic ades_mem;
      logic adel_mem;
      logic overflow;
      logic trap;
   } ExceptinPipeType;

endpackage

// File: rtl/preif_redirect_buf.sv
// Holds a redirect that arrives while the front end is stalled until IF can advance.
module preif_redirect_buf
   import preif_pc_gen_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr,
   input  logic        br_redirect,
   input  logic [31:0] br_target,
   input  logic        exc_redirect,
   input  logic [31:0] exc_pc,
   output logic        hold_br,
   output logic        hold_exc,
   output logic [31:0] pend_target
);

   typedef enum logic [1:0] {StRun, StHoldBr, StHoldExc} state_e;

   state_e      state_q, state_d;
   logic [31:0] pend_q, pend_d;

   // Next state: advancing consumes any pending redirect; otherwise latch by priority.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      if (wr) begin
         state_d = StRun;
         pend_d  = '0;
      end else if (exc_redirect) begin
         // Exception beats any pending or simultaneous branch.
         state_d = StHoldExc;
         pend_d  = exc_pc;
      end else if (br_redirect && state_q != StHoldExc) begin
         // Newer branch replaces an older pending one; dropped behind an exception.
         state_d = StHoldBr;
         pend_d  = br_target;
      end
   end

   // State and pending-target registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   assign hold_br     = (state_q == StHoldBr);
   assign hold_exc    = (state_q == StHoldExc);
   assign pend_target = pend_q;

endmodule

// File: rtl/preif_pc_gen.sv
// PREIF program-counter generator: sequential fetch, branch and exception redirects.
module preif_pc_gen
   import preif_pc_gen_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PREIF_Wr,
   input  logic            BR_Redirect,
   input  logic [31:0]     BR_Target,
   input  logic            EXC_Redirect,
   input  logic [31:0]     EXC_PC,
   output logic [31:0]     PREIF_PC,
   output ExceptinPipeType PREIF_ExceptType,
   output logic            PREIF_Valid
);

   logic [31:0] pc_q, next_pc, pend_target;
   logic        valid_q, hold_br, hold_exc;

   preif_redirect_buf u_redirect_buf (
      .clk          (clk),
      .rst          (rst),
      .wr           (PREIF_Wr),
      .br_redirect  (BR_Redirect),
      .br_target    (BR_Target),
      .exc_redirect (EXC_Redirect),
      .exc_pc       (EXC_PC),
      .hold_br      (hold_br),
      .hold_exc     (hold_exc),
      .pend_target  (pend_target)
   );

   // Next-PC priority: live exception, held exception, live branch, held branch, PC+4.
   always_comb begin
      next_pc = pc_q + 32'd4;
      if (EXC_Redirect) begin
         next_pc = EXC_PC;
      end else if (hold_exc) begin
         next_pc = pend_target;
      end else if (BR_Redirect) begin
         next_pc = BR_Target;
      end else if (hold_br) begin
         next_pc = pend_target;
      end
   end

   // PC register advances only when IF accepts; valid rises on the first edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b1;
         if (PREIF_Wr) begin
            pc_q <= next_pc;
         end
      end
   end

   // Fetch exception depends only on the registered PC alignment.
   always_comb begin
      PREIF_ExceptType         = '0;
      PREIF_ExceptType.adel_if = |pc_q[1:0];
   end

   assign PREIF_PC    = pc_q;
   assign PREIF_Valid = valid_q;

endmodule

// File: tb/tb_preif_pc_gen.sv
// Directed self-checking bench for preif_pc_gen.
module tb_preif_pc_gen;
   import preif_pc_gen_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            PREIF_Wr;
   logic            BR_Redirect;
   logic [31:0]     BR_Target;
   logic            EXC_Redirect;
   logic [31:0]     EXC_PC;
   logic [31:0]     PREIF_PC;
   ExceptinPipeType PREIF_ExceptType;
   logic            PREIF_Valid;

   int total  = 0;
   int passed = 0;

   preif_pc_gen dut (
      .clk              (clk),
      .rst              (rst),
      .PREIF_Wr         (PREIF_Wr),
      .BR_Redirect      (BR_Redirect),
      .BR_Target        (BR_Target),
      .EXC_Redirect     (EXC_Redirect),
      .EXC_PC           (EXC_PC),
      .PREIF_PC         (PREIF_PC),
      .PREIF_ExceptType (PREIF_ExceptType),
      .PREIF_Valid      (PREIF_Valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic exp_adel);
      chk({tag, "_pc"}, PREIF_PC, exp_pc);
      chk({tag, "_adel"}, 32'(PREIF_ExceptType.adel_if), 32'(exp_adel));
   endtask

   initial begin
      rst = 1'b1; PREIF_Wr = 1'b0; BR_Redirect = 1'b0; BR_Target = '0;
      EXC_Redirect = 1'b0; EXC_PC = '0;
      #3;
      chk("rst_pc", PREIF_PC, 32'hBFC0_0000);
      chk("rst_valid", 32'(PREIF_Valid), 32'd0);
      chk("rst_exc", 32'(PREIF_ExceptType), 32'd0);
      #4 rst = 1'b0; PREIF_Wr = 1'b1;
      chk("rel_valid", 32'(PREIF_Valid), 32'd0);

      // Sequential fetch
      tick(); chk_pc("seq1", 32'hBFC0_0004, 1'b0);
      chk("seq1_valid", 32'(PREIF_Valid), 32'd1);
      tick(); chk_pc("seq2", 32'hBFC0_0008, 1'b0);
      tick(); chk_pc("seq3", 32'hBFC0_000C, 1'b0);

      // Branch during stall
      PREIF_Wr = 1'b0; BR_Redirect = 1'b1; BR_Target = 32'h8000_1000;
      tick(); chk_pc("stall_br1", 32'hBFC0_000C, 1'b0);
      BR_Redirect = 1'b0;
      tick(); chk_pc("stall_br2", 32'hBFC0_000C, 1'b0);
      tick(); chk_pc("stall_br3", 32'hBFC0_000C, 1'b0);
      PREIF_Wr = 1'b1;
      tick(); chk_pc("br_release", 32'h8000_1000, 1'b0);

      // BR then EXC then BR while stalled: exception wins
      PREIF_Wr = 1'b0; BR_Redirect = 1'b1; BR_Target = 32'h8000_1000;
      tick(); BR_Redirect = 1'b0; EXC_Redirect = 1'b1; EXC_PC = 32'hBFC0_0380;
      tick(); EXC_Redirect = 1'b0; BR_Redirect = 1'b1; BR_Target = 32'h8000_2000;
      tick(); BR_Redirect = 1'b0;
      chk_pc("hold_exc", 32'h8000_1000, 1'b0);
      PREIF_Wr = 1'b1;
      tick(); chk_pc("exc_release", 32'hBFC0_0380, 1'b0);

      // Simultaneous EXC and BR while advancing
      EXC_Redirect = 1'b1; EXC_PC = 32'hBFC0_0380;
      BR_Redirect = 1'b1; BR_Target = 32'h8000_1000;
      tick(); chk_pc("simul", 32'hBFC0_0380, 1'b0);
      EXC_Redirect = 1'b0; BR_Redirect = 1'b0;
      tick(); chk_pc("simul_next", 32'hBFC0_0384, 1'b0);

      // Misaligned target
      BR_Redirect = 1'b1; BR_Target = 32'h8000_1002;
      tick(); chk_pc("mis1", 32'h8000_1002, 1'b1);
      BR_Redirect = 1'b0;
      tick(); chk_pc("mis2", 32'h8000_1006, 1'b1);

      // Wrap-around
      BR_Redirect = 1'b1; BR_Target = 32'hFFFF_FFFC;
      tick(); chk_pc("wrap1", 32'hFFFF_FFFC, 1'b0);
      BR_Redirect = 1'b0;
      tick(); chk_pc("wrap2", 32'h0000_0000, 1'b0);

      // Simultaneous EXC and BR while already holding a branch
      PREIF_Wr = 1'b0; BR_Redirect = 1'b1; BR_Target = 32'h8000_3000;
      tick(); EXC_Redirect = 1'b1; EXC_PC = 32'h8000_0180; BR_Target = 32'h8000_4000;
      tick(); EXC_Redirect = 1'b0; BR_Redirect = 1'b0; PREIF_Wr = 1'b1;
      tick(); chk_pc("hold_simul", 32'h8000_0180, 1'b0);

      // Newer branch replaces older pending branch
      PREIF_Wr = 1'b0; BR_Redirect = 1'b1; BR_Target = 32'h8000_5000;
      tick(); BR_Target = 32'h8000_6000;
      tick(); BR_Redirect = 1'b0; PREIF_Wr = 1'b1;
      tick(); chk_pc("br_replace", 32'h8000_6000, 1'b0);
      tick(); chk_pc("br_replace_next", 32'h8000_6004, 1'b0);

      // Reset mid-HOLD_BR
      PREIF_Wr = 1'b0; BR_Redirect = 1'b1; BR_Target = 32'h8000_7000;
      tick(); BR_Redirect = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_pc", PREIF_PC, 32'hBFC0_0000);
      chk("midrst_valid", 32'(PREIF_Valid), 32'd0);
      #2 rst = 1'b0;
      tick(); chk_pc("postrst_stall", 32'hBFC0_0000, 1'b0);
      chk("postrst_valid", 32'(PREIF_Valid), 32'd1);
      PREIF_Wr = 1'b1;
      tick(); chk_pc("postrst_adv", 32'hBFC0_0004, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
